// File: rtl/fetch_stage_queued.sv
// Fetch stage with an instruction queue.
// It owns the PC, issues word fetches to an in-order, variable-latency
// instruction memory, buffers the returned words with their PC in a
// FETCH_DEPTH-entry queue, and presents the queue head to decode over a
// valid/ready handshake. A redirect from execute flushes the queue. The same
// redirect marks every request still in flight to be discarded when it
// returns.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   PCSrcE, PCTargetE        redirect request and target from execute
//   imem_req, imem_addr      fetch request/address (memory never stalls)
//   imem_rvalid, imem_rdata  in-order fetch response
//   ValidD, ReadyD           decode handshake for the queue head
//   InstrD, PCD, PCPlus4D    queue head payload (zero when queue is empty)
module fetch_stage_queued #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     FETCH_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            ValidD,
  input  logic            ReadyD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);

  localparam int unsigned PW = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FETCH_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_n;
  // PC of the next response that will be kept (responses are in order and
  // kept ones form a contiguous sequence starting at the last redirect)
  logic [XLEN-1:0] resp_pc_q, resp_pc_n;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_n, wr_ptr_q, wr_ptr_n;
  logic [CW-1:0]   count_q, count_n, outst_q, outst_n, drop_q, drop_n;

  logic [31:0]     instr_mem [FETCH_DEPTH];
  logic [XLEN-1:0] pc_mem    [FETCH_DEPTH];

  logic [CW:0]     occupancy;
  logic [XLEN-1:0] target;
  logic            accept;
  logic            pop;

  assign target    = {PCTargetE[XLEN-1:2], 2'b00};
  assign occupancy = (CW+1)'(outst_q) + (CW+1)'(count_q);

  // Issue only while every in-flight response is guaranteed a queue slot
  assign imem_req  = !rst && !PCSrcE && (occupancy < (CW+1)'(FETCH_DEPTH));
  assign imem_addr = pc_q;

  assign ValidD   = !rst && (count_q != '0);
  assign InstrD   = ValidD ? instr_mem[rd_ptr_q] : '0;
  assign PCD      = ValidD ? pc_mem[rd_ptr_q] : '0;
  assign PCPlus4D = ValidD ? pc_mem[rd_ptr_q] + XLEN'(4) : '0;

  assign pop    = ValidD && ReadyD;
  assign accept = imem_rvalid && !PCSrcE && (drop_q == '0);

  // Next-state for PC, queue bookkeeping and wrong-path drop counter
  always_comb begin
    pc_n      = pc_q;
    resp_pc_n = resp_pc_q;
    rd_ptr_n  = rd_ptr_q;
    wr_ptr_n  = wr_ptr_q;
    count_n   = count_q;
    outst_n   = outst_q + CW'(imem_req) - CW'(imem_rvalid);
    drop_n    = drop_q;

    if (imem_req) pc_n = pc_q + XLEN'(4);
    if (imem_rvalid && (drop_q != '0)) drop_n = drop_q - CW'(1);

    if (accept) begin
      wr_ptr_n  = wr_ptr_q + PW'(1);
      resp_pc_n = resp_pc_q + XLEN'(4);
    end
    if (pop) rd_ptr_n = rd_ptr_q + PW'(1);
    count_n = count_q + CW'(accept) - CW'(pop);

    // Everything still outstanding after this cycle belongs to the wrong path
    if (PCSrcE) begin
      pc_n      = target;
      resp_pc_n = target;
      rd_ptr_n  = '0;
      wr_ptr_n  = '0;
      count_n   = '0;
      drop_n    = outst_n;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_n;
      resp_pc_q <= resp_pc_n;
      rd_ptr_q  <= rd_ptr_n;
      wr_ptr_q  <= wr_ptr_n;
      count_q   <= count_n;
      outst_q   <= outst_n;
      drop_q    <= drop_n;
    end
  end

  // Queue storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage_queued.sv
// Self-checking bench for fetch_stage_queued: randomized decode back-pressure,
// memory latency, redirects and resets against an occupancy/epoch model and
// an architectural expected-PC scoreboard.
module tb_fetch_stage_queued;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        ReadyD = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  fetch_stage_queued #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .FETCH_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ValidD(ValidD), .ReadyD(ReadyD), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int          due;
  } req_t;

  req_t        pend[$];          // requests held by the memory model
  logic [31:0] exp_q[$];         // PCs decode must receive, in order
  logic [31:0] addr_q[$];        // addresses fetch must issue, in order
  logic [31:0] next_exp, next_addr;
  int unsigned epoch = 0;        // bumps on every redirect/reset
  int unsigned buffered = 0;     // words the queue should hold
  int          cyc = 0;
  int          mem_lat = 1;      // 0 selects a random latency of 1..3
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_pops = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'h13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: expectation queue empty (cycle %0d)", name, cyc);
  endtask

  function automatic void refill();
    while (exp_q.size() < 16) begin exp_q.push_back(next_exp); next_exp += 32'd4; end
    while (addr_q.size() < 16) begin addr_q.push_back(next_addr); next_addr += 32'd4; end
  endfunction

  function automatic void set_base(input logic [31:0] pc);
    exp_q.delete();
    addr_q.delete();
    next_exp  = pc;
    next_addr = pc;
    refill();
  endfunction

  // Memory model plus checking monitor, evaluated mid-cycle
  always @(negedge clk) begin : env_monitor
    req_t        e;
    bit          rv, exp_req, pop_m;
    int          lat, due;
    logic [31:0] x;

    cyc++;
    rv = !rst && (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend[0].addr) : 32'h0;

    exp_req = !rst && !PCSrcE && ((pend.size() + buffered) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (imem_req) begin
      if (addr_q.size() == 0) fail_now("imem_addr");
      else chk("imem_addr", imem_addr, addr_q.pop_front());
    end

    chk("ValidD", 32'(ValidD), 32'(!rst && (buffered != 0)));
    if (!ValidD) chk("idle_outputs_zero", InstrD | PCD | PCPlus4D, 32'h0);

    if (ValidD && ReadyD && !PCSrcE && !rst) begin
      n_pops++;
      if (exp_q.size() == 0) fail_now("decode_pc");
      else begin
        x = exp_q.pop_front();
        chk("PCD", PCD, x);
        chk("PCPlus4D", PCPlus4D, x + 32'd4);
        chk("InstrD", InstrD, mem_word(x));
      end
    end

    pop_m = !rst && (buffered != 0) && ReadyD && !PCSrcE;
    if (rst) begin
      pend.delete();
      buffered = 0;
      epoch++;
    end else begin
      if (rv) begin
        e = pend.pop_front();
        if (e.epoch == epoch && !PCSrcE) buffered++;
      end
      if (pop_m) buffered--;
      if (PCSrcE) begin
        buffered = 0;
        epoch++;
      end
      if (imem_req) begin
        lat = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
        due = cyc + lat;
        if (pend.size() > 0 && pend[$].due >= due) due = pend[$].due + 1;
        e.addr  = imem_addr;
        e.epoch = epoch;
        e.due   = due;
        pend.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic redirect(input logic [31:0] t);
    PCSrcE    = 1'b1;
    PCTargetE = t;
    set_base(t & ~32'h3);
    step();
    PCSrcE = 1'b0;
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    set_base(RESET_PC);
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin : stimulus
    int r;
    ReadyD = 1'b1;
    set_base(RESET_PC);
    repeat (3) step();
    rst = 1'b0;

    // streaming with 1-cycle memory
    mem_lat = 1;
    repeat (12) step();
    // decode stalls: queue fills, issue stops, head holds
    ReadyD = 1'b0;
    repeat (10) step();
    ReadyD = 1'b1;
    repeat (10) step();
    // redirect with slow memory and requests in flight
    mem_lat = 3;
    repeat (6) step();
    redirect(32'h200);
    repeat (12) step();
    // redirect coinciding with a response, unaligned target
    mem_lat = 1;
    repeat (6) step();
    redirect(32'h103);
    repeat (8) step();
    // PC wrap across the top of the address space
    redirect(32'hFFFF_FFF8);
    repeat (10) step();
    // reset with a full queue and requests outstanding
    ReadyD  = 1'b0;
    mem_lat = 4;
    repeat (3) step();
    mem_lat = 1;
    repeat (2) step();
    mem_lat = 4;
    repeat (1) step();
    pulse_reset(1);
    ReadyD  = 1'b1;
    mem_lat = 1;
    repeat (10) step();

    // randomized traffic
    mem_lat = 0;
    repeat (500) begin
      ReadyD = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 99));
      if (r < 5) redirect($urandom());
      else if (r < 6) pulse_reset(int'($urandom_range(1, 2)));
      else step();
    end

    ReadyD = 1'b1;
    repeat (10) step();
    chk("decode_progress", 32'(n_pops >= 100), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
